// File: rtl/tl_rx_vc_pkg.sv
// Shared encodings and header-field helpers for the RX virtual-channel buffer read side.
// Pure definitions: no logic, no state.
package tl_rx_vc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HDR_OUT  = 2'd1,
    ST_DATA_OUT = 2'd2
  } state_t;

  localparam int FMT_DATA_BIT = 30;
  localparam int LEN_MSB      = 9;
  localparam int LEN_LSB      = 0;
  localparam int LEN_WIDTH    = LEN_MSB - LEN_LSB + 1;
  localparam int MAX_BEATS    = 256;

  // A Length of zero encodes 1024 DW; one beat carries 4 DW.
  function automatic logic [8:0] beats(input logic [LEN_WIDTH-1:0] len);
    logic [10:0] l;
    logic [10:0] sum;
    l   = (len == '0) ? 11'd1024 : {1'b0, len};
    sum = l + 11'd3;
    return sum[10:2];
  endfunction

endpackage

// File: rtl/tl_rx_vc_beat_cntr.sv
// Remaining-beat counter for the TLP being streamed: loads on header pop, counts down per beat.
// Registered count, is_last combinational from it; holds when no beat transfers.
module tl_rx_vc_beat_cntr
  import tl_rx_vc_pkg::*;
#(
  parameter int BEAT_CNT_WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [LEN_WIDTH-1:0]      len,
  input  logic                      dec,
  output logic [BEAT_CNT_WIDTH-1:0] cnt,
  output logic                      is_last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= BEAT_CNT_WIDTH'(beats(len));
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_last = (cnt == BEAT_CNT_WIDTH'(1));

endmodule

// File: rtl/tl_rx_vc_buffer_reader.sv
// Pops whole TLPs from one RX VC store; header valid 1 cycle after pop, beats stream 1/cycle.
// Ready low or data store empty freezes state and pointers; credits return on every pop.
module tl_rx_vc_buffer_reader
  import tl_rx_vc_pkg::*;
#(
  parameter int HDR_WIDTH      = 128,
  parameter int DATA_WIDTH     = 128,
  parameter int BEAT_CNT_WIDTH = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_hdr_empty,
  input  logic                  i_data_empty,
  input  logic [HDR_WIDTH-1:0]  i_hdr_rd_data,
  input  logic [DATA_WIDTH-1:0] i_data_rd_data,
  output logic                  o_r_hdr_inc,
  output logic                  o_r_data_inc,
  output logic [HDR_WIDTH-1:0]  o_tlp_hdr,
  output logic                  o_tlp_hdr_valid,
  input  logic                  i_tlp_hdr_ready,
  output logic [DATA_WIDTH-1:0] o_tlp_data,
  output logic                  o_tlp_data_valid,
  output logic                  o_tlp_data_last,
  input  logic                  i_tlp_data_ready,
  output logic                  o_fc_hdr_ret,
  output logic                  o_fc_data_ret,
  output logic                  o_busy
);

  state_t                    state;
  state_t                    state_nxt;
  logic                      has_data;
  logic                      hdr_pop;
  logic                      data_xfer;
  logic                      is_last;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt;

  always_comb begin
    state_nxt        = state;
    hdr_pop          = 1'b0;
    data_xfer        = 1'b0;
    o_tlp_hdr_valid  = 1'b0;
    o_tlp_data_valid = 1'b0;
    o_tlp_data_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        // Reset gating keeps the store untouched while the block is held in reset.
        if (!i_hdr_empty && !i_rst) begin
          hdr_pop   = 1'b1;
          state_nxt = ST_HDR_OUT;
        end
      end
      ST_HDR_OUT: begin
        o_tlp_hdr_valid = 1'b1;
        if (i_tlp_hdr_ready) begin
          state_nxt = has_data ? ST_DATA_OUT : ST_IDLE;
        end
      end
      ST_DATA_OUT: begin
        o_tlp_data_valid = ~i_data_empty;
        o_tlp_data_last  = is_last;
        data_xfer        = ~i_data_empty & i_tlp_data_ready;
        if (data_xfer && is_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      o_tlp_hdr <= '0;
      has_data  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hdr_pop) begin
        o_tlp_hdr <= i_hdr_rd_data;
        has_data  <= i_hdr_rd_data[FMT_DATA_BIT];
      end
    end
  end

  tl_rx_vc_beat_cntr #(
    .BEAT_CNT_WIDTH(BEAT_CNT_WIDTH)
  ) u_beat_cntr (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (hdr_pop),
    .len     (i_hdr_rd_data[LEN_MSB:LEN_LSB]),
    .dec     (data_xfer),
    .cnt     (beat_cnt),
    .is_last (is_last)
  );

  // Header credit returns at pop time: the header lives on in o_tlp_hdr.
  assign o_r_hdr_inc   = hdr_pop;
  assign o_fc_hdr_ret  = hdr_pop;
  assign o_r_data_inc  = data_xfer;
  assign o_fc_data_ret = data_xfer;
  assign o_tlp_data    = i_data_rd_data;
  assign o_busy        = (state != ST_IDLE);

endmodule
